// File: rtl/rca_parameterized_if.sv
// Operand/result bundle for the ripple-carry adder.
// master drives operands, slave returns registered results.
interface rca_parameterized_if #(
  parameter int n = 16
);
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         cin;
  logic [n-1:0] sum;
  logic         cout;
  logic [n:0]   final_sum;

  modport master (
    output a, b, cin,
    input  sum, cout, final_sum
  );

  modport slave (
    input  a, b, cin,
    output sum, cout, final_sum
  );
endinterface

// File: rtl/rca_parameterized.sv
// n-bit ripple-carry adder built from explicit full-adder cells.
// Result is registered; final_sum is formed from the same flops.
module rca_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module rca_parameterized #(
  parameter int n = 16
) (
  input  logic               clk,
  input  logic               rst,
  rca_parameterized_if.slave bus
);
  logic [n:0]   c;
  logic [n-1:0] s;
  logic [n-1:0] sum_q;
  logic         cout_q;

  assign c[0] = bus.cin;

  for (genvar i = 0; i < n; i++) begin : g_cell
    rca_fa_cell u_fa (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Capture the ripple result every cycle; async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= s;
      cout_q <= c[n];
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.final_sum = {cout_q, sum_q};
endmodule

// File: tb/tb_rca_parameterized.sv
// Scoreboard bench for rca_parameterized at n = 4, 8, 16, 32.
// Stimulus pushes expected results; monitors pop and compare.
module tb_rca_parameterized;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rca_parameterized_if #(.n(4))  if4  ();
  rca_parameterized_if #(.n(8))  if8  ();
  rca_parameterized_if #(.n(16)) if16 ();
  rca_parameterized_if #(.n(32)) if32 ();

  rca_parameterized #(.n(4))  u4  (.clk(clk), .rst(rst), .bus(if4.slave));
  rca_parameterized #(.n(8))  u8  (.clk(clk), .rst(rst), .bus(if8.slave));
  rca_parameterized #(.n(16)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));
  rca_parameterized #(.n(32)) u32 (.clk(clk), .rst(rst), .bus(if32.slave));

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] q4[$];
  logic [32:0] q8[$];
  logic [32:0] q16[$];
  logic [32:0] q32[$];

  task automatic chk(string nm, logic [32:0] act, logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitors: one result per cycle, sampled 1 ns after the edge.
  always @(posedge clk) begin
    logic [32:0] e;
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("n4 sum", 33'(if4.sum), 33'(e[3:0]));
      chk("n4 cout", 33'(if4.cout), 33'(e[4]));
      chk("n4 final_sum", 33'(if4.final_sum), e);
    end
  end

  always @(posedge clk) begin
    logic [32:0] e;
    #1;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk("n8 sum", 33'(if8.sum), 33'(e[7:0]));
      chk("n8 cout", 33'(if8.cout), 33'(e[8]));
      chk("n8 final_sum", 33'(if8.final_sum), e);
    end
  end

  always @(posedge clk) begin
    logic [32:0] e;
    #1;
    if (q16.size() > 0) begin
      e = q16.pop_front();
      chk("n16 sum", 33'(if16.sum), 33'(e[15:0]));
      chk("n16 cout", 33'(if16.cout), 33'(e[16]));
      chk("n16 final_sum", 33'(if16.final_sum), e);
    end
  end

  always @(posedge clk) begin
    logic [32:0] e;
    #1;
    if (q32.size() > 0) begin
      e = q32.pop_front();
      chk("n32 sum", 33'(if32.sum), 33'(e[31:0]));
      chk("n32 cout", 33'(if32.cout), 33'(e[32]));
      chk("n32 final_sum", 33'(if32.final_sum), e);
    end
  end

  task automatic drv4(logic [3:0] a, logic [3:0] b,
                      logic c, logic [4:0] exp);
    @(negedge clk);
    if4.a = a; if4.b = b; if4.cin = c;
    q4.push_back(33'(exp));
  endtask

  task automatic drv8(logic [7:0] a, logic [7:0] b,
                      logic c, logic [8:0] exp);
    @(negedge clk);
    if8.a = a; if8.b = b; if8.cin = c;
    q8.push_back(33'(exp));
  endtask

  task automatic drv16(logic [15:0] a, logic [15:0] b,
                       logic c, logic [16:0] exp);
    @(negedge clk);
    if16.a = a; if16.b = b; if16.cin = c;
    q16.push_back(33'(exp));
  endtask

  task automatic drv32(logic [31:0] a, logic [31:0] b,
                       logic c, logic [32:0] exp);
    @(negedge clk);
    if32.a = a; if32.b = b; if32.cin = c;
    q32.push_back(exp);
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " n16 sum"}, 33'(if16.sum), 33'd0);
    chk({tag, " n16 cout"}, 33'(if16.cout), 33'd0);
    chk({tag, " n16 final_sum"}, 33'(if16.final_sum), 33'd0);
    chk({tag, " n4 final_sum"}, 33'(if4.final_sum), 33'd0);
    chk({tag, " n8 final_sum"}, 33'(if8.final_sum), 33'd0);
    chk({tag, " n32 final_sum"}, 33'(if32.final_sum), 33'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] re;

    rst = 1'b1;
    if4.a = '1;  if4.b = 4'h1;  if4.cin = 1'b1;
    if8.a = '1;  if8.b = 8'h1;  if8.cin = 1'b1;
    if16.a = 16'hFFFF; if16.b = 16'h0001; if16.cin = 1'b1;
    if32.a = '1; if32.b = 32'h1; if32.cin = 1'b1;

    // reset holds outputs at zero with clk running
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_zero("reset");
    end
    @(negedge clk);
    rst = 1'b0;

    // n = 16 directed
    drv16(16'h0000, 16'h0000, 1'b1, 17'h00001);
    drv16(16'hFFFF, 16'h0000, 1'b1, 17'h10000);
    drv16(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    drv16(16'h1234, 16'h4321, 1'b0, 17'h05555);
    drv16(16'h8000, 16'h8000, 1'b0, 17'h10000);
    drain();

    // n = 4
    drv4(4'hF, 4'h0, 1'b1, 5'h10);
    drv4(4'hF, 4'hF, 1'b1, 5'h1F);
    drv4(4'hF, 4'h1, 1'b0, 5'h10);
    drv4(4'h5, 4'hA, 1'b0, 5'h0F);
    drain();

    // n = 8
    drv8(8'hFF, 8'h00, 1'b1, 9'h100);
    drv8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    drv8(8'h80, 8'h7F, 1'b0, 9'h0FF);
    drain();

    // n = 32
    drv32(32'hFFFF_FFFF, 32'h0, 1'b1, 33'h1_0000_0000);
    drv32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
    drv32(32'h1234_5678, 32'h8765_4321, 1'b1, 33'h0_9999_999A);
    drain();

    // n = 16 random, back to back
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      re = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      drv16(ra, rb, rc, re);
    end
    drv16(16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF);
    drain();

    // async reset between edges clears outputs at once
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async rst");
    @(posedge clk);
    #1;
    chk_zero("rst hold");
    @(negedge clk);
    rst = 1'b0;

    // recovery after reset
    drv16(16'h0001, 16'h0001, 1'b0, 17'h00002);
    drv4(4'h8, 4'h8, 1'b1, 5'h11);
    drain();

    chk("queues drained",
        33'(q4.size() + q8.size() + q16.size() + q32.size()),
        33'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rca_parameterized.md
# rca_parameterized

Parameterized n-bit ripple-carry adder with a registered output stage, used as the baseline in the adder-comparison study (area/delay against faster adder topologies). Adds two n-bit operands and a carry-in through an explicit chain of n full-adder cells. Registers sum, carry-out and the concatenated (n+1)-bit result on the clock.

## Interface
- n, default 16: operand width in bits; legal range n >= 1 (4, 8, 16, 32 exercised).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all output registers.
- a  input  n  operand A, unsigned.
- b  input  n  operand B, unsigned.
- cin  input  1  carry into bit 0.
- sum  output  n  registered sum bits [n-1:0] of a + b + cin.
- cout  output  1  registered carry out of bit n-1.
- final_sum  output  n+1  registered full result; always equals {cout, sum}.

## Operation
- Datapath is a true ripple chain:
  - carry c[0] = cin.
  - For each bit i in 0..n-1, one full-adder cell computes s[i] = a[i] ^ b[i] ^ c[i] and c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]).
  - Cells are instantiated by a generate loop over n.
  - A behavioural "+" operator is not permitted, because the carry-path structure is the object of the comparison.
- Combinational result is {c[n], s[n-1:0]}, i.e. a + b + cin computed modulo 2^(n+1) with no overflow loss.
- Output register:
  - On each rising clk with rst low: sum <= s, cout <= c[n], final_sum <= {c[n], s}.
  - final_sum is built from the same registered bits as sum and cout, so the three outputs never disagree.
- Arithmetic is unsigned. Signed overflow detection is out of scope; cout is the unsigned carry only.
- There is no enable, valid or handshake. A new result is captured every cycle.

## Timing
- Reset:
  - rst high forces sum = 0, cout = 0 and final_sum = 0 immediately, independent of clk.
  - Outputs hold 0 while rst is high.
  - The first capture is the first rising clk after rst deasserts.
- Latency: exactly 1 cycle. Inputs that are stable before rising edge k appear on the outputs after edge k.
- Throughput: one addition per cycle.
- The critical path is cin/a[0]/b[0] through n carry cells to c[n], then the register. The clock period must exceed the n-stage ripple delay.
- Inputs change only between edges. Values present at the edge are the ones captured.
- Reset mid-operation: an in-flight (uncaptured) result is discarded, and the outputs go to 0 asynchronously.
- Reset release must meet recovery/removal timing relative to clk. The design does not synchronize the deasserting edge internally.

## Test plan
- Reset: assert rst with a=16'hFFFF, b=16'h0001, cin=1 and clk running -> sum=0, cout=0, final_sum=0 throughout reset.
- Zero and carry-in (n=16): a=0, b=0, cin=1 -> one cycle later sum=16'h0001, cout=0, final_sum=17'h00001.
- Full ripple (n=16): a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, final_sum=17'h10000. This confirms the carry propagates through all n cells.
- Maximum (n=16): a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1, final_sum=17'h1FFFF.
- Randomized (n=16): 200 cycles of random a, b and cin -> every cycle final_sum == a+b+cin from the previous cycle, and final_sum == {cout, sum}.
- Width sweep:
  - Repeat the full-ripple and maximum cases at n=4, 8 and 32.
  - At n=4, a=4'hF, b=4'h1, cin=0 -> sum=4'h0, cout=1, final_sum=5'h10.
  - Assert rst mid-stream -> outputs go to 0 without waiting for clk.
